pxs_pattern_gen: RTL and testbench
==================================

Name: pxs_pattern_gen

Overview:
- Multi-mode test-pattern generator on the iPxs pixel stream: takes a VGA stream without colour, adds RGB from one of 8 selectable patterns, and forwards HS, VS, XC, YC and Active with matched latency.
- Sits between the VGA timing source and any Pxs filter or sink; replaces the single fixed XOR colouring with selectable, scalable and animated patterns.
- Mode and scale changes are frame-synchronous, so there is no tearing.

Parameters:
- H_ACTIVE, 640, active pixels per line; colour-bar width is H_ACTIVE/8 (must divide exactly).
- FCW, 8, frame-counter width.
- VS_ACTIVE, 0, VS assertion level; a frame starts on the edge into this level.
- SCROLL_STEP, 1, XC offset added per frame in animated mode (mod 2^10).

Ports:
- px_clk  in  1  pixel clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mode_i  in  3  requested pattern; sampled at frame start only.
- shift_i  in  4  pattern scale (coordinate right-shift 0..9, values >9 clamp to 9); sampled at frame start only.
- VGAStr_i  in  23  input stream; field positions per the Pxs.vh macros.
- RGBStr_o  out  26  output stream (R, G, B, HS, VS, XC, YC, Active per Pxs.vh); registered.
- frame_o  out  FCW  frames seen since reset; wraps.

Behaviour:
- Reset (async assert, sync release): RGBStr_o = 0, frame_o = 0, mode register = 0, shift register = 0, bar counters = 0, pipeline registers = 0.
- Latency: exactly 2 px_clk.
  - Stage 1 registers the input fields and the scaled coordinates xs = XC>>shift and ys = YC>>shift.
  - Stage 2 computes RGB and registers the full output.
  - HS, VS, XC, YC and Active on RGBStr_o equal VGAStr_i from 2 cycles earlier, unmodified.
- Frame start: VS transitions into VS_ACTIVE, using a 1-cycle delayed compare on the input stream. On that cycle:
  - frame_o increments;
  - mode_i and shift_i are latched into internal registers.
  - The latched values apply from the next input pixel onward.
  - A mode change mid-frame has no effect until the next frame start.
- Pattern per latched mode, with {R,G,B} as 3 bits:
  - 0 XOR: c = xs ^ ys; {R,G,B} = {c[0],c[1],c[2]}.
  - 1 checkerboard: all three = xs[0] ^ ys[0].
  - 2 colour bars, left to right: 111, 110, 011, 010, 101, 100, 001, 000.
  - 3 H gradient: {R,G,B} = xs[2:0].
  - 4 V gradient: {R,G,B} = ys[2:0].
  - 5 solid white: 111.
  - 6 animated XOR: c = ((XC + frame*SCROLL_STEP) mod 1024 >> shift) ^ ys; {R,G,B} = {c[0],c[1],c[2]}. Frame is the value at pixel time.
  - 7 black: 000.
- Colour-bar engine (sequential, runs in every mode):
  - Pixel counter and 3-bit bar index are cleared on the Active rising edge.
  - The pixel counter counts active pixels; at H_ACTIVE/8-1 it wraps to 0 and the bar index increments.
  - The bar index saturates at 7 and does not wrap to 0 within a line.
  - Pixels with Active=0 hold both counters.
- Blanking: if the stage-2 Active bit is 0, RGB = 000 regardless of mode.
- frame_o wraps from 2^FCW-1 to 0 with no flag.
- Reset mid-frame: all state clears at once. The first frame start after release latches mode/shift; until then mode 0 with shift 0 is used.
- Shift clamp: values above 9 are treated as 9.

Decomposition:
- Shared package/header (Pxs.vh): stream field macros (R, G, B, HS, VS, XC, YC, Active), stream widths 23/26, mode encodings PXS_PAT_XOR..PXS_PAT_BLACK, and the colour-bar RGB constant table.
- One natural sub-module, pxs_bar_counter: the Active-edge-cleared pixel/bar counter with H_ACTIVE parameter, outputting the 3-bit bar index aligned to stage 1.

Test Plan:
- Reset then idle:
  - Assert reset mid-stream → RGBStr_o = 0 and frame_o = 0 immediately (async).
  - After release with mode_i=2 held but no frame start yet → XOR pattern (mode 0) appears.
- XOR, mode 0, shift 0, after one frame start:
  - XC=5, YC=3 → RGB = {0,1,1}, appearing exactly 2 cycles later.
  - Sync fields are bit-identical to the input delayed 2 cycles.
- Colour bars, mode 2, H_ACTIVE=640:
  - Pixels 0..79 → 111; pixel 80 → 110; pixel 639 → 000.
  - Next line restarts at 111.
  - Active=0 pixels → 000.
- Frame-synchronous switch: change mode_i 0→5 mid-frame → output stays XOR until the VS edge; the first pixel after it → 111.
- Animated mode 6, SCROLL_STEP=1: pixel at XC=1023, YC=0 with frame_o=1 → c = 0, RGB = 000 (coordinate wrap); frame_o reaches 255 then 0 after 256 frames.
- Scale: mode 1, shift_i=3 → checker squares 8×8 (XC 0..7 = 0, XC 8..15 = 1 on YC=0); shift_i=15 behaves as shift 9.

Source files
------------

// File: rtl/pxs_pattern_gen_pkg.sv
// ---------------------------------------------------------------------------
// pxs_pattern_gen_pkg
//   Shared definitions for the iPxs test-pattern generator:
//   - stream field positions for the 23-bit VGA stream and 26-bit RGB stream
//   - pattern mode encodings
//   - colour-bar RGB table and shift clamp helper
// ---------------------------------------------------------------------------
package pxs_pattern_gen_pkg;

    // Stream widths.
    localparam int VGA_W = 23;
    localparam int RGB_W = 26;

    // Coordinate width.
    localparam int CW = 10;

    // Field positions. The RGB stream is the VGA stream with {R,G,B}
    // prepended at the top.
    localparam int ACT_BIT = 0;
    localparam int YC_LSB  = 1;
    localparam int XC_LSB  = 11;
    localparam int VS_BIT  = 21;
    localparam int HS_BIT  = 22;
    localparam int B_BIT   = 23;
    localparam int G_BIT   = 24;
    localparam int R_BIT   = 25;

    // Largest usable coordinate shift.
    localparam logic [3:0] SHIFT_MAX = 4'd9;

    typedef enum logic [2:0] {
        PXS_PAT_XOR     = 3'd0,
        PXS_PAT_CHECKER = 3'd1,
        PXS_PAT_BARS    = 3'd2,
        PXS_PAT_HGRAD   = 3'd3,
        PXS_PAT_VGRAD   = 3'd4,
        PXS_PAT_WHITE   = 3'd5,
        PXS_PAT_ANIM    = 3'd6,
        PXS_PAT_BLACK   = 3'd7
    } pxs_pat_t;

    // Colour-bar colours, left to right, as {R,G,B}.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
    endfunction

    function automatic logic [3:0] clamp_shift(input logic [3:0] s);
        clamp_shift = (s > SHIFT_MAX) ? SHIFT_MAX : s;
    endfunction

endpackage

// File: rtl/pxs_pattern_gen_bar_counter.sv
// ---------------------------------------------------------------------------
// pxs_bar_counter
//   Counts active pixels within a line and produces the colour-bar index.
//   The counters restart on every Active rising edge; the bar index steps
//   every H_ACTIVE/8 active pixels and saturates at 7.
// Ports:
//   px_clk  in   pixel clock
//   reset   in   asynchronous active-high reset
//   active  in   Active bit of the incoming (stage-0) pixel
//   bar     out  bar index of that pixel, registered (aligned to stage 1)
// ---------------------------------------------------------------------------
module pxs_bar_counter #(
    parameter int H_ACTIVE = 640
) (
    input  logic       px_clk,
    input  logic       reset,
    input  logic       active,
    output logic [2:0] bar
);

    localparam int BAR_W = H_ACTIVE / 8;
    localparam int CNT_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic             act_d;
    logic             rise;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] cur_cnt;
    logic [2:0]       bar_idx;
    logic [2:0]       cur_bar;

    // Position of the current pixel: the first pixel after an Active rising
    // edge is pixel 0 of bar 0 regardless of what the counters held.
    always_comb begin
        rise    = active & ~act_d;
        cur_cnt = rise ? '0 : pix_cnt;
        cur_bar = rise ? 3'd0 : bar_idx;
    end

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            act_d   <= 1'b0;
            pix_cnt <= '0;
            bar_idx <= 3'd0;
            bar     <= 3'd0;
        end else begin
            act_d <= active;
            bar   <= cur_bar;
            // Blanking pixels leave both counters untouched.
            if (active) begin
                if (cur_cnt == CNT_W'(BAR_W - 1)) begin
                    pix_cnt <= '0;
                    bar_idx <= (cur_bar == 3'd7) ? 3'd7 : cur_bar + 3'd1;
                end else begin
                    pix_cnt <= cur_cnt + 1'b1;
                    bar_idx <= cur_bar;
                end
            end
        end
    end

endmodule

// File: rtl/pxs_pattern_gen.sv
// ---------------------------------------------------------------------------
// pxs_pattern_gen
//   Test-pattern generator on the iPxs pixel stream. Adds RGB from one of
//   eight patterns to a colourless VGA stream; sync/coordinate fields pass
//   through with a fixed 2-cycle latency. Mode and scale are latched only at
//   frame start so a frame never mixes two patterns.
// Ports:
//   px_clk    in   pixel clock
//   reset     in   asynchronous active-high reset
//   mode_i    in   requested pattern (latched at frame start)
//   shift_i   in   coordinate right-shift, clamped to 9 (latched at frame start)
//   VGAStr_i  in   23-bit VGA stream {HS, VS, XC, YC, Active}
//   RGBStr_o  out  26-bit RGB stream {R, G, B, HS, VS, XC, YC, Active}
//   frame_o   out  frame-start count since reset, wrapping
// ---------------------------------------------------------------------------
module pxs_pattern_gen
    import pxs_pattern_gen_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int FCW         = 8,
    parameter int VS_ACTIVE   = 0,
    parameter int SCROLL_STEP = 1
) (
    input  logic             px_clk,
    input  logic             reset,
    input  logic [2:0]       mode_i,
    input  logic [3:0]       shift_i,
    input  logic [VGA_W-1:0] VGAStr_i,
    output logic [RGB_W-1:0] RGBStr_o,
    output logic [FCW-1:0]   frame_o
);

    localparam logic          VS_LVL = 1'(VS_ACTIVE);
    localparam logic [CW-1:0] STEP   = CW'(SCROLL_STEP);

    // Stage 0: incoming pixel.
    logic          in_vs;
    logic          vs_d;
    logic          frame_start;
    logic [CW-1:0] in_xc;
    logic [CW-1:0] in_yc;
    logic [CW-1:0] scroll;
    logic [CW-1:0] xa;

    // Frame-latched controls.
    pxs_pat_t   mode_r;
    logic [3:0] shift_r;

    // Stage 1. Every pattern only looks at the low three bits of the scaled
    // coordinates, so only those are kept.
    logic [VGA_W-1:0] s1_vga;
    logic [2:0]       s1_xs;
    logic [2:0]       s1_ys;
    logic [2:0]       s1_xas;
    pxs_pat_t         s1_mode;
    logic [2:0]       s1_bar;

    // Stage 2 combinational result.
    logic [2:0]       c_xor;
    logic [2:0]       c_anim;
    logic [2:0]       rgb;
    logic [RGB_W-1:0] px_out;

    assign in_vs  = VGAStr_i[VS_BIT];
    assign in_xc  = VGAStr_i[XC_LSB +: CW];
    assign in_yc  = VGAStr_i[YC_LSB +: CW];

    // Frame start is the first input pixel whose VS sits at the active level
    // after a pixel that did not.
    assign frame_start = (in_vs == VS_LVL) && (vs_d != VS_LVL);

    // Scroll offset is taken modulo 2^CW, so truncating the frame count to
    // CW bits before multiplying gives the same result.
    assign scroll = CW'(frame_o) * STEP;
    assign xa     = in_xc + scroll;

    pxs_bar_counter #(
        .H_ACTIVE (H_ACTIVE)
    ) u_bar_counter (
        .px_clk (px_clk),
        .reset  (reset),
        .active (VGAStr_i[ACT_BIT]),
        .bar    (s1_bar)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the values from before the edge; the frame-start pixel itself
    // is therefore still coloured with the previous mode and shift.
    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            vs_d     <= 1'b0;
            frame_o  <= '0;
            mode_r   <= PXS_PAT_XOR;
            shift_r  <= 4'd0;
            s1_vga   <= '0;
            s1_xs    <= 3'd0;
            s1_ys    <= 3'd0;
            s1_xas   <= 3'd0;
            s1_mode  <= PXS_PAT_XOR;
            RGBStr_o <= '0;
        end else begin
            vs_d <= in_vs;
            if (frame_start) begin
                frame_o <= frame_o + 1'b1;
                mode_r  <= pxs_pat_t'(mode_i);
                shift_r <= clamp_shift(shift_i);
            end
            s1_vga   <= VGAStr_i;
            s1_xs    <= 3'(in_xc >> shift_r);
            s1_ys    <= 3'(in_yc >> shift_r);
            s1_xas   <= 3'(xa >> shift_r);
            s1_mode  <= mode_r;
            RGBStr_o <= px_out;
        end
    end

    assign c_xor  = s1_xs ^ s1_ys;
    assign c_anim = s1_xas ^ s1_ys;

    // NOTE: rgb and px_out get a full default before the case so no path
    // leaves them unassigned, which would otherwise infer latches.
    always_comb begin
        rgb = 3'b000;
        case (s1_mode)
            PXS_PAT_XOR:     rgb = {c_xor[0], c_xor[1], c_xor[2]};
            PXS_PAT_CHECKER: rgb = {3{s1_xs[0] ^ s1_ys[0]}};
            PXS_PAT_BARS:    rgb = bar_rgb(s1_bar);
            PXS_PAT_HGRAD:   rgb = s1_xs;
            PXS_PAT_VGRAD:   rgb = s1_ys;
            PXS_PAT_WHITE:   rgb = 3'b111;
            PXS_PAT_ANIM:    rgb = {c_anim[0], c_anim[1], c_anim[2]};
            PXS_PAT_BLACK:   rgb = 3'b000;
            default:         rgb = 3'b000;
        endcase
        if (!s1_vga[ACT_BIT]) begin
            rgb = 3'b000;
        end

        px_out                 = '0;
        px_out[R_BIT]          = rgb[2];
        px_out[G_BIT]          = rgb[1];
        px_out[B_BIT]          = rgb[0];
        px_out[HS_BIT]         = s1_vga[HS_BIT];
        px_out[VS_BIT]         = s1_vga[VS_BIT];
        px_out[XC_LSB +: CW]   = s1_vga[XC_LSB +: CW];
        px_out[YC_LSB +: CW]   = s1_vga[YC_LSB +: CW];
        px_out[ACT_BIT]        = s1_vga[ACT_BIT];
    end

endmodule

// File: tb/tb_pxs_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_pxs_pattern_gen
//   Directed bench for pxs_pattern_gen. Each driven pixel pushes its
//   expected 26-bit output word onto a scoreboard queue; the word is popped
//   and compared when the pixel emerges two clocks later.
// ---------------------------------------------------------------------------
module tb_pxs_pattern_gen;
    import pxs_pattern_gen_pkg::*;

    localparam int H_ACTIVE    = 640;
    localparam int FCW         = 8;
    localparam int VS_ACTIVE   = 0;
    localparam int SCROLL_STEP = 1;

    logic             px_clk = 1'b0;
    logic             reset;
    logic [2:0]       mode_i;
    logic [3:0]       shift_i;
    logic [VGA_W-1:0] vga;
    logic [RGB_W-1:0] rgb_str;
    logic [FCW-1:0]   frame_o;

    always #5 px_clk = ~px_clk;

    pxs_pattern_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .FCW         (FCW),
        .VS_ACTIVE   (VS_ACTIVE),
        .SCROLL_STEP (SCROLL_STEP)
    ) dut (
        .px_clk   (px_clk),
        .reset    (reset),
        .mode_i   (mode_i),
        .shift_i  (shift_i),
        .VGAStr_i (vga),
        .RGBStr_o (rgb_str),
        .frame_o  (frame_o)
    );

    typedef struct {
        logic [RGB_W-1:0] exp;
        string            tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state.
    logic [2:0]     m_mode;
    int             m_shift;
    logic [FCW-1:0] m_frame;
    logic           m_vs_prev;
    logic           m_act_prev;
    int             m_px;
    logic [2:0]     bar_tab [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                    3'b101, 3'b100, 3'b001, 3'b000};

    task automatic model_reset();
        m_mode     = 3'd0;
        m_shift    = 0;
        m_frame    = '0;
        m_vs_prev  = 1'b0;
        m_act_prev = 1'b0;
        m_px       = 0;
        sb.delete();
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one pixel, predict its output, advance one clock and compare
    // whatever output is now due.
    task automatic px(input logic hs, input logic vs, input logic act,
                      input int xc, input int yc, input string tag);
        logic [VGA_W-1:0] v;
        logic [RGB_W-1:0] eo;
        logic [2:0]       c3;
        logic [2:0]       rgb;
        logic             fs;
        int               xs, ys, c, bi;
        exp_t             e;

        v               = '0;
        v[HS_BIT]       = hs;
        v[VS_BIT]       = vs;
        v[XC_LSB +: CW] = xc[9:0];
        v[YC_LSB +: CW] = yc[9:0];
        v[ACT_BIT]      = act;
        vga             = v;

        fs = (vs == 1'(VS_ACTIVE)) && (m_vs_prev != 1'(VS_ACTIVE));
        xs = (xc % 1024) >> m_shift;
        ys = (yc % 1024) >> m_shift;
        if (act && !m_act_prev) m_px = 0;
        bi = m_px / (H_ACTIVE / 8);
        if (bi > 7) bi = 7;

        case (m_mode)
            3'd0: begin c = xs ^ ys; c3 = c[2:0]; rgb = {c3[0], c3[1], c3[2]}; end
            3'd1: rgb = {3{xs[0] ^ ys[0]}};
            3'd2: rgb = bar_tab[bi];
            3'd3: rgb = xs[2:0];
            3'd4: rgb = ys[2:0];
            3'd5: rgb = 3'b111;
            3'd6: begin
                c   = (((xc + int'(m_frame) * SCROLL_STEP) % 1024) >> m_shift) ^ ys;
                c3  = c[2:0];
                rgb = {c3[0], c3[1], c3[2]};
            end
            default: rgb = 3'b000;
        endcase
        if (!act) rgb = 3'b000;

        eo            = '0;
        eo[R_BIT]     = rgb[2];
        eo[G_BIT]     = rgb[1];
        eo[B_BIT]     = rgb[0];
        eo[VGA_W-1:0] = v;
        e.exp = eo;
        e.tag = tag;
        sb.push_back(e);

        if (act) m_px++;
        m_act_prev = act;
        m_vs_prev  = vs;
        if (fs) begin
            m_frame = m_frame + 1'b1;
            m_mode  = mode_i;
            m_shift = (shift_i > 4'd9) ? 9 : int'(shift_i);
        end

        @(posedge px_clk);
        #1;
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            checks++;
            assert (rgb_str === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, rgb_str, e.exp);
            end
        end
    endtask

    // Blank pixel with VS inactive, VS active, then inactive again.
    task automatic frame_start(input string tag);
        px(1'b0, 1'b1, 1'b0, 0, 0, tag);
        px(1'b0, 1'b0, 1'b0, 0, 0, tag);
        check_val({tag, "_frame"}, 32'(frame_o), 32'(m_frame));
        px(1'b0, 1'b1, 1'b0, 0, 0, tag);
    endtask

    task automatic video_line(input int yc, input string tag);
        for (int i = 0; i < 3; i++) px(1'b1, 1'b1, 1'b0, 0, yc, {tag, "_blank"});
        for (int x = 0; x < H_ACTIVE; x++) px(1'b0, 1'b1, 1'b1, x, yc, tag);
        for (int i = 0; i < 3; i++) px(1'b1, 1'b1, 1'b0, 0, yc, {tag, "_blank"});
    endtask

    // Asynchronous reset taken between clock edges.
    task automatic mid_reset(input string tag);
        #3;
        reset = 1'b1;
        #1;
        check_val({tag, "_rgb_zero"}, 32'(rgb_str), 32'd0);
        check_val({tag, "_frame_zero"}, 32'(frame_o), 32'd0);
        model_reset();
        @(posedge px_clk);
        @(negedge px_clk);
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        vga     = '0;
        mode_i  = 3'd2;
        shift_i = 4'd0;
        model_reset();
        repeat (3) @(posedge px_clk);
        @(negedge px_clk);
        reset = 1'b0;

        // No frame start yet: mode 0 / shift 0 even though mode_i = 2.
        for (int x = 0; x < 16; x++) px(1'b0, 1'b1, 1'b1, x, 3, "pre_fs_xor");

        // XOR, including XC=5 YC=3 -> {0,1,1}; HS toggles to vary sync bits.
        mode_i = 3'd0;
        frame_start("fs_xor");
        px(1'b0, 1'b1, 1'b1, 5, 3, "xor_5_3");
        for (int i = 0; i < 8; i++)
            px(i[0], 1'b1, 1'b1, 5 + i * 37, 3 + i * 11, "xor_mix");

        // Colour bars over two full lines.
        mode_i = 3'd2;
        frame_start("fs_bars");
        video_line(0, "bars_l0");
        video_line(1, "bars_l1");

        // Frame-synchronous switch 0 -> 5.
        mode_i = 3'd0;
        frame_start("fs_sw");
        for (int x = 0; x < 4; x++) px(1'b0, 1'b1, 1'b1, x + 9, 6, "switch_xor");
        mode_i = 3'd5;
        for (int x = 0; x < 6; x++) px(1'b0, 1'b1, 1'b1, x + 13, 6, "switch_hold");
        frame_start("fs_sw2");
        for (int x = 0; x < 4; x++) px(1'b0, 1'b1, 1'b1, x, 0, "switch_white");

        // Checkerboard scaling, shift 3 then clamped shift 15.
        mode_i  = 3'd1;
        shift_i = 4'd3;
        frame_start("fs_chk3");
        for (int x = 0; x < 16; x++) px(1'b0, 1'b1, 1'b1, x, 0, "chk_s3");
        shift_i = 4'd15;
        frame_start("fs_chk15");
        for (int y = 0; y < 3; y++) begin
            px(1'b0, 1'b1, 1'b1, 0,    y * 512, "chk_s15");
            px(1'b0, 1'b1, 1'b1, 511,  y * 512, "chk_s15");
            px(1'b0, 1'b1, 1'b1, 512,  y * 512, "chk_s15");
            px(1'b0, 1'b1, 1'b1, 1023, y * 512, "chk_s15");
        end

        // Gradients.
        mode_i  = 3'd3;
        shift_i = 4'd1;
        frame_start("fs_hgrad");
        for (int x = 0; x < 16; x++) px(1'b0, 1'b1, 1'b1, x, 5, "hgrad");
        mode_i  = 3'd4;
        shift_i = 4'd2;
        frame_start("fs_vgrad");
        for (int y = 0; y < 32; y += 3) px(1'b0, 1'b1, 1'b1, 7, y, "vgrad");

        // Reset mid-stream while white is showing.
        mode_i  = 3'd5;
        shift_i = 4'd0;
        frame_start("fs_white");
        for (int x = 0; x < 4; x++) px(1'b1, 1'b1, 1'b1, x, 2, "white");
        mid_reset("rst_mid");

        // Animated XOR: frame 1, XC=1023 wraps to 0.
        mode_i = 3'd6;
        for (int x = 0; x < 4; x++) px(1'b0, 1'b1, 1'b1, x, 1, "post_rst_xor");
        frame_start("fs_anim");
        px(1'b0, 1'b1, 1'b1, 1023, 0, "anim_wrap");
        px(1'b0, 1'b1, 1'b1, 1022, 0, "anim");
        px(1'b0, 1'b1, 1'b1, 100,  5, "anim");
        px(1'b0, 1'b1, 1'b1, 0,    0, "anim");

        // Frame counter wrap after reset.
        mid_reset("rst_wrap");
        mode_i = 3'd7;
        for (int f = 0; f < 255; f++) frame_start("fs_loop");
        check_val("frame_255", 32'(frame_o), 32'd255);
        frame_start("fs_last");
        check_val("frame_wrap0", 32'(frame_o), 32'd0);
        for (int x = 0; x < 4; x++) px(1'b0, 1'b1, 1'b1, x + 40, 9, "black");

        // Flush the pipeline.
        px(1'b0, 1'b1, 1'b0, 0, 0, "flush");
        px(1'b0, 1'b1, 1'b0, 0, 0, "flush");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
